// File: rtl/pc_sel_predict.sv
// Next-PC select for the two-stage RV32I core: fetch-time prediction from a
// bimodal BHT (branches) or statically taken (JAL), EX-stage resolution and redirect.
module pc_sel_predict #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 64,
    parameter int ENABLE_PRED = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic [31:0]      fetch_inst,
    input  logic             ex_valid,
    input  logic [31:0]      ex_inst,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic [1:0]       PCSignal,
    output logic [XLEN-1:0]  pc_tgt,
    output logic             pred_taken,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_ALU   = 2'b01;
    localparam logic [1:0] SEL_PLUS4 = 2'b10;
    localparam logic [1:0] SEL_TGT   = 2'b11;

    logic [1:0]       bht_q [DEPTH];
    logic [1:0]       bht_d [DEPTH];
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // ---------------- fetch-side prediction ----------------
    logic [6:0]       f_op;
    logic [IDX_W-1:0] f_idx;
    logic [XLEN-1:0]  f_bimm, f_jimm, f_pc_plus4, f_tgt;
    logic             f_pred;

    assign f_op       = fetch_inst[6:0];
    assign f_idx      = fetch_pc[IDX_W+1:2];
    assign f_pc_plus4 = fetch_pc + XLEN'(4);
    assign f_bimm     = {{(XLEN-12){fetch_inst[31]}}, fetch_inst[7], fetch_inst[30:25],
                         fetch_inst[11:8], 1'b0};
    assign f_jimm     = {{(XLEN-20){fetch_inst[31]}}, fetch_inst[19:12], fetch_inst[20],
                         fetch_inst[30:21], 1'b0};

    always_comb begin
        f_pred = 1'b0;
        f_tgt  = f_pc_plus4;
        if (f_op == OP_JAL) begin
            f_pred = 1'b1;
            f_tgt  = fetch_pc + f_jimm;
        end else if (f_op == OP_BRANCH) begin
            f_pred = (ENABLE_PRED != 0) ? bht_q[f_idx][1] : 1'b0;
            f_tgt  = fetch_pc + f_bimm;
        end
    end

    // ---------------- EX-side resolution ----------------
    logic [6:0]       x_op;
    logic [2:0]       x_f3;
    logic [4:0]       x_rd;
    logic [IDX_W-1:0] x_idx;
    logic             x_cond, x_taken, x_mispred, x_jalr, x_writes_rd, jalr_hazard;

    assign x_op  = ex_inst[6:0];
    assign x_f3  = ex_inst[14:12];
    assign x_rd  = ex_inst[11:7];
    assign x_idx = ex_pc[IDX_W+1:2];

    // funct3 010/011 are not real branches: never counted, never trained
    always_comb begin
        x_cond  = 1'b0;
        x_taken = 1'b0;
        if (ex_valid && (x_op == OP_BRANCH)) begin
            x_cond = 1'b1;
            case (x_f3)
                3'b000:         x_taken = BrEq;
                3'b001:         x_taken = !BrEq;
                3'b100, 3'b110: x_taken = BrLT;
                3'b101, 3'b111: x_taken = !BrLT;
                default:        x_cond  = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (x_op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: x_writes_rd = 1'b1;
            default: x_writes_rd = 1'b0;
        endcase
    end

    assign x_mispred   = x_cond && (x_taken != ex_pred_taken);
    assign x_jalr      = ex_valid && (x_op == OP_JALR);
    assign jalr_hazard = (f_op == OP_JALR) && ex_valid && x_writes_rd &&
                         (x_rd != 5'd0) && (x_rd == fetch_inst[19:15]);

    // ---------------- next-PC select ----------------
    always_comb begin
        PCSignal = SEL_PLUS4;
        pc_tgt   = f_pc_plus4;
        flush    = 1'b0;
        if (x_jalr) begin
            PCSignal = SEL_ALU;
            flush    = 1'b1;
        end else if (x_mispred && x_taken) begin
            PCSignal = SEL_ALU;
            flush    = 1'b1;
        end else if (x_mispred) begin
            PCSignal = SEL_TGT;
            pc_tgt   = ex_pc + XLEN'(4);
            flush    = 1'b1;
        end else if (stall || jalr_hazard) begin
            PCSignal = SEL_HOLD;
        end else if (f_pred) begin
            PCSignal = SEL_TGT;
            pc_tgt   = f_tgt;
        end
    end

    assign pred_taken = f_pred;

    // ---------------- training and statistics ----------------
    always_comb begin
        bht_d = bht_q;
        if ((ENABLE_PRED != 0) && x_cond) begin
            if (x_taken && (bht_q[x_idx] != 2'b11)) begin
                bht_d[x_idx] = bht_q[x_idx] + 2'd1;
            end else if (!x_taken && (bht_q[x_idx] != 2'b00)) begin
                bht_d[x_idx] = bht_q[x_idx] - 2'd1;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (x_cond) begin
            if (branch_count_q != {CNT_W{1'b1}}) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
            if (x_mispred && (mispredict_count_q != {CNT_W{1'b1}})) begin
                mispredict_count_d = mispredict_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    // ex_target is consumed by the PC mux outside this block
    logic unused_ok;
    assign unused_ok = ^{ex_inst[31:15], ex_target};

endmodule

// File: tb/tb_pc_sel_predict.sv
// Bench for pc_sel_predict: a predicting instance and a static, narrow-counter
// instance share stimulus and are checked each cycle against an ISA-level model.
module tb_pc_sel_predict;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] fetch_pc, fetch_inst, ex_inst, ex_pc, ex_target;
    logic        ex_valid, ex_pred_taken, br_eq, br_lt;

    logic [1:0]  d1_sel, d2_sel;
    logic [31:0] d1_tgt, d2_tgt;
    logic        d1_pred, d2_pred, d1_flush, d2_flush;
    logic [31:0] d1_bc, d1_mc;
    logic [2:0]  d2_bc, d2_mc;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam longint MAX1 = 64'hFFFF_FFFF;
    localparam longint MAX2 = 7;

    pc_sel_predict dut1 (
        .clk(clk), .rst(rst), .stall(stall), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_target(ex_target), .BrEq(br_eq), .BrLT(br_lt), .PCSignal(d1_sel), .pc_tgt(d1_tgt),
        .pred_taken(d1_pred), .flush(d1_flush), .branch_count(d1_bc), .mispredict_count(d1_mc)
    );

    pc_sel_predict #(.XLEN(32), .DEPTH(8), .ENABLE_PRED(0), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_target(ex_target), .BrEq(br_eq), .BrLT(br_lt), .PCSignal(d2_sel), .pc_tgt(d2_tgt),
        .pred_taken(d2_pred), .flush(d2_flush), .branch_count(d2_bc), .mispredict_count(d2_mc)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int imm);
        logic [12:0] i;
        i = 13'(imm);
        return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input int imm);
        logic [20:0] i;
        i = 21'(imm);
        return {i[20], i[10:1], i[11], i[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input int imm);
        return {12'(imm), rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
        logic [11:0] i;
        i = 12'(imm);
        return {i[11:5], rs2, rs1, 3'b010, i[4:0], 7'h23};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        pred;
        logic        flush;
    } exp_t;

    int     m_bht [64];
    longint m_bc1, m_mc1, m_bc2, m_mc2;
    int     f_slot, x_slot;

    assign f_slot = int'((fetch_pc >> 2) % 64);
    assign x_slot = int'((ex_pc >> 2) % 64);

    function automatic bit ex_counted();
        if (!ex_valid || ex_inst[6:0] != 7'h63) return 1'b0;
        return !(ex_inst[14:12] == 3'd2 || ex_inst[14:12] == 3'd3);
    endfunction

    function automatic bit ex_taken();
        case (int'(ex_inst[14:12]))
            0:       return br_eq;
            1:       return !br_eq;
            4, 6:    return br_lt;
            default: return !br_lt;
        endcase
    endfunction

    function automatic bit writes_rd(input logic [6:0] op);
        return op == 7'h37 || op == 7'h17 || op == 7'h6f || op == 7'h67 ||
               op == 7'h03 || op == 7'h13 || op == 7'h33;
    endfunction

    function automatic exp_t model_eval(input bit en, input int ctr);
        exp_t e;
        int   bimm, jimm;
        bit   f_br, f_jal, f_jalr, x_jalr, tk, mis, hazard;
        logic [31:0] ptgt;
        f_br   = fetch_inst[6:0] == 7'h63;
        f_jal  = fetch_inst[6:0] == 7'h6f;
        f_jalr = fetch_inst[6:0] == 7'h67;
        bimm = {fetch_inst[31], fetch_inst[7], fetch_inst[30:25], fetch_inst[11:8], 1'b0};
        if (bimm >= 4096) bimm -= 8192;
        jimm = {fetch_inst[31], fetch_inst[19:12], fetch_inst[20], fetch_inst[30:21], 1'b0};
        if (jimm >= (1 << 20)) jimm -= (1 << 21);
        ptgt   = f_jal ? fetch_pc + 32'(jimm) : fetch_pc + 32'(bimm);
        e.pred = f_jal || (f_br && en && ctr >= 2);
        tk     = ex_taken();
        mis    = ex_counted() && (tk != ex_pred_taken);
        x_jalr = ex_valid && ex_inst[6:0] == 7'h67;
        hazard = f_jalr && ex_valid && writes_rd(ex_inst[6:0]) && ex_inst[11:7] != 0 &&
                 ex_inst[11:7] == fetch_inst[19:15];
        e.tgt   = fetch_pc + 32'd4;
        e.flush = 1'b0;
        if (x_jalr || (mis && tk)) begin
            e.sel = 2'b01; e.flush = 1'b1;
        end else if (mis) begin
            e.sel = 2'b11; e.tgt = ex_pc + 32'd4; e.flush = 1'b1;
        end else if (stall || hazard) begin
            e.sel = 2'b00;
        end else if (e.pred) begin
            e.sel = 2'b11; e.tgt = ptgt;
        end else begin
            e.sel = 2'b10;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) m_bht[i] <= 1;
            m_bc1 <= 0; m_mc1 <= 0; m_bc2 <= 0; m_mc2 <= 0;
        end else if (ex_counted()) begin
            if (ex_taken()) begin
                if (m_bht[x_slot] < 3) m_bht[x_slot] <= m_bht[x_slot] + 1;
            end else begin
                if (m_bht[x_slot] > 0) m_bht[x_slot] <= m_bht[x_slot] - 1;
            end
            if (m_bc1 < MAX1) m_bc1 <= m_bc1 + 1;
            if (m_bc2 < MAX2) m_bc2 <= m_bc2 + 1;
            if (ex_taken() != ex_pred_taken) begin
                if (m_mc1 < MAX1) m_mc1 <= m_mc1 + 1;
                if (m_mc2 < MAX2) m_mc2 <= m_mc2 + 1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input exp_t e, input logic [1:0] sel,
                           input logic [31:0] tgt, input logic pred, input logic flush,
                           input logic [31:0] bc, input logic [31:0] mc,
                           input longint ebc, input longint emc);
        chk({tag, "_sel"}, 32'(sel), 32'(e.sel));
        if (e.sel == 2'b11) chk({tag, "_tgt"}, tgt, e.tgt);
        chk({tag, "_pred"}, 32'(pred), 32'(e.pred));
        chk({tag, "_flush"}, 32'(flush), 32'(e.flush));
        chk({tag, "_bcount"}, bc, 32'(ebc));
        chk({tag, "_mcount"}, mc, 32'(emc));
    endtask

    always @(negedge clk) begin
        cmp_dut("m1", model_eval(1'b1, m_bht[f_slot]), d1_sel, d1_tgt, d1_pred, d1_flush,
                d1_bc, d1_mc, m_bc1, m_mc1);
        cmp_dut("m2", model_eval(1'b0, 0), d2_sel, d2_tgt, d2_pred, d2_flush,
                32'(d2_bc), 32'(d2_mc), m_bc2, m_mc2);
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        stall = 1'b0; fetch_pc = 32'h400; fetch_inst = NOP;
        ex_valid = 1'b0; ex_inst = NOP; ex_pc = 32'h0; ex_pred_taken = 1'b0;
        ex_target = 32'h0; br_eq = 1'b0; br_lt = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic ex_branch(input logic [31:0] pc, input logic [2:0] f3, input logic eq,
                             input logic lt, input logic pred);
        ex_valid = 1'b1; ex_pc = pc; ex_inst = enc_b(f3, 16); ex_target = pc + 32'd16;
        br_eq = eq; br_lt = lt; ex_pred_taken = pred;
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic        eq;
        logic        lt;
        logic        pred;
        logic [31:0] pc;
    } br_vec_t;

    br_vec_t sat_tbl [6] = '{
        '{3'b000, 1'b1, 1'b0, 1'b1, 32'h800}, '{3'b001, 1'b1, 1'b0, 1'b0, 32'h804},
        '{3'b100, 1'b0, 1'b1, 1'b0, 32'h808}, '{3'b101, 1'b0, 1'b1, 1'b0, 32'h80C},
        '{3'b110, 1'b0, 1'b0, 1'b1, 32'h810}, '{3'b111, 1'b0, 1'b0, 1'b1, 32'h814}
    };

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        set_idle();
        fetch_pc = 32'h100; fetch_inst = enc_b(3'b000, 16);
        settle();
        chk("reset_sel", 32'(d1_sel), 32'h2);
        chk("reset_pred", 32'(d1_pred), 32'h0);
        chk("reset_bcount", d1_bc, 32'h0);
        chk("reset_mcount2", 32'(d2_mc), 32'h0);
        #2 rst = 1'b1;

        // static-predictor instance: taken BGEU always redirects
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            ex_branch(32'h304, 3'b111, 1'b0, 1'b0, 1'b0);
            settle();
            chk("static_bgeu_sel", 32'(d2_sel), 32'h1);
            chk("static_bgeu_flush", 32'(d2_flush), 32'h1);
        end
        next_cycle();
        fetch_pc = 32'h304; fetch_inst = enc_b(3'b111, 32);
        settle();
        chk("static_pred", 32'(d2_pred), 32'h0);
        chk("static_mcount", 32'(d2_mc), 32'h4);
        chk("trained_pred", 32'(d1_pred), 32'h1);
        chk("trained_tgt", d1_tgt, 32'h324);

        // asynchronous reset mid-cycle clears BHT and counters immediately
        rst = 1'b0;
        #1;
        chk("async_rst_pred", 32'(d1_pred), 32'h0);
        chk("async_rst_bcount", d1_bc, 32'h0);
        chk("async_rst_mcount2", 32'(d2_mc), 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;

        next_cycle();
        fetch_pc = 32'h100; fetch_inst = enc_b(3'b000, 16);
        settle();
        chk("beq_fetch_pred", 32'(d1_pred), 32'h0);
        chk("beq_fetch_sel", 32'(d1_sel), 32'h2);
        chk("model_bht_init", 32'(m_bht[0]), 32'h1);

        for (int k = 0; k < 2; k++) begin
            next_cycle();
            fetch_pc = 32'h104;
            ex_branch(32'h100, 3'b000, 1'b1, 1'b0, 1'b0);
            settle();
            chk("beq_resolve_sel", 32'(d1_sel), 32'h1);
            chk("beq_resolve_flush", 32'(d1_flush), 32'h1);
        end
        next_cycle();
        fetch_pc = 32'h100; fetch_inst = enc_b(3'b000, 16);
        settle();
        chk("model_bht_strong", 32'(m_bht[0]), 32'h3);
        chk("beq_pred_taken", 32'(d1_pred), 32'h1);
        chk("beq_pred_sel", 32'(d1_sel), 32'h3);
        chk("beq_pred_tgt", d1_tgt, 32'h110);
        chk("beq_bcount", d1_bc, 32'h2);
        chk("beq_mcount", d1_mc, 32'h2);

        // BNE wrongly predicted taken: redirect to fall-through
        next_cycle();
        ex_branch(32'h200, 3'b001, 1'b1, 1'b0, 1'b1);
        settle();
        chk("bne_sel", 32'(d1_sel), 32'h3);
        chk("bne_tgt", d1_tgt, 32'h204);
        chk("bne_flush", 32'(d1_flush), 32'h1);
        next_cycle();
        settle();
        chk("bne_mcount", d1_mc, 32'h3);
        next_cycle();
        ex_branch(32'h200, 3'b001, 1'b1, 1'b0, 1'b0);
        settle();
        chk("bne_ok_sel", 32'(d1_sel), 32'h2);
        next_cycle();
        fetch_pc = 32'h100; fetch_inst = enc_b(3'b000, 16);
        settle();
        chk("bht_decayed_pred", 32'(d1_pred), 32'h0);

        // JALR read-after-write hold
        next_cycle();
        fetch_pc = 32'h500; fetch_inst = enc_i(7'h67, 5'd1, 5'd5, 0);
        ex_valid = 1'b1; ex_inst = enc_i(7'h13, 5'd5, 5'd0, 1);
        settle();
        chk("jalr_hazard_sel", 32'(d1_sel), 32'h0);
        next_cycle();
        fetch_pc = 32'h500; fetch_inst = enc_i(7'h67, 5'd1, 5'd5, 0);
        ex_valid = 1'b1; ex_inst = enc_i(7'h13, 5'd0, 5'd0, 1);
        settle();
        chk("jalr_x0_sel", 32'(d1_sel), 32'h2);
        next_cycle();
        fetch_pc = 32'h500; fetch_inst = enc_i(7'h67, 5'd1, 5'd5, 0);
        ex_valid = 1'b1; ex_inst = enc_s(5'd3, 5'd4, 5);
        settle();
        chk("jalr_store_sel", 32'(d1_sel), 32'h2);

        // redirect beats stall
        next_cycle();
        stall = 1'b1;
        ex_branch(32'h600, 3'b100, 1'b0, 1'b1, 1'b0);
        settle();
        chk("stall_redirect_sel", 32'(d1_sel), 32'h1);
        chk("stall_redirect_flush", 32'(d1_flush), 32'h1);
        next_cycle();
        stall = 1'b1; fetch_pc = 32'h100; fetch_inst = enc_b(3'b000, 16);
        settle();
        chk("stall_hold_sel", 32'(d1_sel), 32'h0);
        chk("stall_hold_flush", 32'(d1_flush), 32'h0);

        // JAL predicted at fetch, silent in EX; JALR in EX always redirects
        next_cycle();
        fetch_pc = 32'h700; fetch_inst = enc_j(5'd1, -8);
        settle();
        chk("jal_pred", 32'(d1_pred), 32'h1);
        chk("jal_tgt", d1_tgt, 32'h6F8);
        next_cycle();
        ex_valid = 1'b1; ex_inst = enc_j(5'd1, 16);
        settle();
        chk("ex_jal_sel", 32'(d1_sel), 32'h2);
        next_cycle();
        stall = 1'b1; ex_valid = 1'b1; ex_inst = enc_i(7'h67, 5'd0, 5'd1, 0);
        settle();
        chk("ex_jalr_sel", 32'(d1_sel), 32'h1);
        chk("ex_jalr_flush", 32'(d1_flush), 32'h1);
        next_cycle();
        fetch_pc = 32'hFFFF_FFFC; fetch_inst = enc_j(5'd0, 8);
        settle();
        chk("jal_wrap_tgt", d1_tgt, 32'h4);

        // funct3 010 in EX: ignored
        next_cycle();
        ex_branch(32'h900, 3'b010, 1'b1, 1'b1, 1'b1);
        settle();
        chk("f3_010_sel", 32'(d1_sel), 32'h2);
        next_cycle();
        settle();
        chk("f3_010_bcount", d1_bc, 32'h5);

        // push the 3-bit counters into saturation
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            ex_branch(sat_tbl[k].pc, sat_tbl[k].f3, sat_tbl[k].eq, sat_tbl[k].lt, sat_tbl[k].pred);
            settle();
        end
        next_cycle();
        settle();
        chk("sat_bcount2", 32'(d2_bc), 32'h7);
        chk("bcount1_after_table", d1_bc, 32'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
